uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver (8N1, LSB first) feeding the processor's serial input: turns the `rxd` pin into bytes for the miner's work-loading path.
- Synchronises `rxd`, oversamples, validates start and stop bits, and pushes good bytes into a small first-word-fall-through FIFO.
- The consumer pops bytes with a valid/ready handshake.
- Framing errors and overruns are reported as single-cycle pulses.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz (10 ns period).
- BAUD, 115200, line rate in bits per second.
- OVERSAMPLE, 16, sample ticks per bit.
- FIFO_DEPTH, 4, byte entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rxd  in  1  asynchronous serial line; idle high
- rx_data  out  8  FIFO head byte; valid only while rx_valid=1
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  consumer accepts the head byte this cycle when rx_valid=1
- rx_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: good byte dropped because the FIFO was full
- busy  out  1  high whenever the FSM is not in IDLE

Interface (already decided):
- One clock, `clk`.
- Reset `reset` is synchronous and active-high.

Behaviour:
- Reset (synchronous, active-high): FSM goes to IDLE, FIFO is emptied, tick and bit counters are cleared, and both synchroniser flops are set to 1.
- Output values during and after reset: rx_valid=0, rx_count=0, rx_data=0, frame_err=0, overrun=0, busy=0.
- Reset asserted mid-frame abandons the partial byte and produces no pulses.
- Synchroniser: two flops on rxd; the FSM sees only the synchronised value `rxs` (2-cycle latency).
- Tick generator:
  - Divisor TICK_DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer-truncated (54 with the defaults).
  - A one-cycle `tick` fires every TICK_DIV clocks.
  - The counter restarts at 0 on the cycle the FSM leaves IDLE, so the sample phase is aligned to the detected start edge.
- FSM (advances only on tick, except where noted):
  - IDLE: on rxs=0 (checked every clk) go to START and clear the tick counter.
  - START: after OVERSAMPLE/2 ticks (mid start bit), resample. If rxs=1 it was a glitch: return to IDLE with no pulse. If rxs=0, go to DATA with bit index 0.
  - DATA: every OVERSAMPLE ticks, shift rxs into bit[index]. After index 7, go to STOP.
  - STOP: after OVERSAMPLE ticks, sample rxs.
    - If rxs=1: push the byte and go to IDLE.
    - If rxs=0: pulse frame_err, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxs=1 (checked every clk), then go to IDLE. This covers a break or a line held low from power-up: exactly one frame_err pulse, no bytes, and no re-arm until the line returns high.
- Push timing: the byte is written on the same clk edge as the stop-bit sample. rx_valid (if the FIFO was empty) and the updated rx_count appear on the next cycle.
- FIFO:
  - First-word fall-through: rx_data always shows the oldest entry.
  - A pop happens when rx_valid and rx_ready are both 1.
  - Read and write pointers are one bit wider than the index, so full and empty are unambiguous.
- FIFO boundary conditions:
  - Push when full, with no pop in the same cycle: byte dropped, overrun pulses for one cycle, contents unchanged.
  - Push and pop in the same cycle when full: both succeed, no overrun, count unchanged.
  - Push and pop in the same cycle otherwise: count unchanged, data order preserved.
  - Pop when empty: ignored.
- Other outputs:
  - frame_err and overrun never assert in the same cycle.
  - busy = (state != IDLE).

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, STOP, WAIT_IDLE).
  - Default CLK_HZ and BAUD constants.
  - A TICK_DIV compute function, reused by a later uart_tx.
- One sub-module, `byte_fifo` (params WIDTH=8, DEPTH), containing the FIFO storage, pointers, count, and full/empty logic.
- The top level holds the synchroniser, tick generator and FSM.

Test Plan:
- Idle line, then frame 0xA5 at 115200 (bit period 8680 ns) -> exactly one push.
  - rx_valid rises 1 clk after the stop-bit mid-sample, within one bit period of the stop-bit centre.
  - rx_data=0xA5, rx_count=1.
  - Pop with rx_ready=1 -> rx_valid=0, rx_count=0.
- Glitch: rxd low for 200 ns (under OVERSAMPLE/2 ticks), then high -> no push, no frame_err, busy returns to 0.
- rxd held at 0 from reset for 1 ms (the processor-level bench default) -> exactly one frame_err pulse about 9.5 bit times after reset release, rx_valid stays 0, busy stays 1. Then rxd=1 -> busy=0 within 3 clks.
- Five back-to-back bytes 0x01..0x05 with rx_ready=0 -> rx_count=4 and one overrun pulse at the fifth stop sample. Draining then yields 0x01,0x02,0x03,0x04 in order.
- FIFO full with rx_ready=1 held across the next stop sample -> no overrun, rx_count stays 4, 0x06 is the last byte drained.
- reset pulsed for 1 clk at bit 4 of a frame 0x3C, followed by a clean 0x5A -> no push from the aborted frame, no error pulse, and the next frame received as 0x5A.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and the
// oversample tick divisor used by the receive and transmit blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } uart_state_e;

    localparam int unsigned DEF_CLK_HZ = 100_000_000;
    localparam int unsigned DEF_BAUD   = 115_200;

    // Integer-truncated clocks per oversample tick.
    function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                  input int unsigned baud,
                                                  input int unsigned oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; reports a one-cycle
// overrun pulse when a write is refused because the FIFO is full.
module byte_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overrun
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW:0]                 wr_ptr, rd_ptr;
    logic                        empty, full, do_pop, do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = !empty && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = wr_en && (!full || do_pop);

    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign rd_valid = !empty;
    assign count    = wr_ptr - rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= wr_en && full && !do_pop;
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: rxd synchroniser, oversample tick generator and framing
// FSM feeding a byte FIFO drained by a valid/ready consumer.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          frame_err,
    output logic                          overrun,
    output logic                          busy
);
    localparam int unsigned TICK_DIV = calc_tick_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned TW       = $clog2(TICK_DIV + 1);
    localparam int unsigned OW       = $clog2(OVERSAMPLE);

    uart_state_e   state;
    logic          sync1, rxs;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [OW-1:0] scnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_sample, push;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    assign tick = (tcnt == TW'(TICK_DIV - 1));

    // Restarting on start-edge detection aligns tick phase to the frame.
    always_ff @(posedge clk) begin
        if (reset)
            tcnt <= '0;
        else if ((state == ST_IDLE && !rxs) || tick)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    // The byte is pushed on the same edge the stop bit is sampled high.
    assign stop_sample = (state == ST_STOP) && tick && (scnt == OW'(OVERSAMPLE - 1));
    assign push        = stop_sample && rxs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            scnt      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state <= ST_START;
                        scnt  <= '0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (scnt == OW'(OVERSAMPLE/2 - 1)) begin
                            scnt    <= '0;
                            bit_idx <= '0;
                            state   <= rxs ? ST_IDLE : ST_DATA;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (scnt == OW'(OVERSAMPLE - 1)) begin
                            scnt           <= '0;
                            shreg[bit_idx] <= rxs;
                            if (bit_idx == 3'd7)
                                state <= ST_STOP;
                            else
                                bit_idx <= bit_idx + 1'b1;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (scnt == OW'(OVERSAMPLE - 1)) begin
                            scnt <= '0;
                            if (rxs) begin
                                state <= ST_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_WAIT_IDLE;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rxs)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (push),
        .wr_data  (shreg),
        .rd_data  (rx_data),
        .rd_valid (rx_valid),
        .rd_ready (rx_ready),
        .count    (rx_count),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a queue model of received bytes checked every cycle,
// plus directed frames with hand-computed expectations.
module tb_uart_rx_fifo;
    // Clock rate scaled so one oversample tick is 8 clocks (128 clocks/bit).
    localparam int CLK_HZ = 14_745_600;
    localparam int BAUD   = 115_200;
    localparam int OS     = 16;
    localparam int DEPTH  = 4;
    localparam int TD     = CLK_HZ / (BAUD * OS);
    localparam int BIT    = TD * OS;
    // Frame cycle whose following edge is the stop-bit mid-sample:
    // 3 edges to detect the start edge, then OS/2 + 9*OS ticks.
    localparam int C_PUSH = 2 + TD * (OS/2 + 9*OS);

    logic       clk = 1'b0;
    logic       reset, rxd, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;
    logic [2:0] rx_count;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_count(rx_count), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [7:0] q[$];
    int checks = 0, failures = 0, exp_ov = 0;
    int cyc = 0, fe_cnt = 0, ov_cnt = 0, fe_cyc = 0, ov_cyc = 0, vrise_cyc = 0;
    bit chk_en = 0, prev_v = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
        if (overrun) begin ov_cnt++; ov_cyc = cyc; end
        if (rx_valid && !prev_v) vrise_cyc = cyc;
        prev_v = rx_valid;
        if (chk_en) begin
            check("model_valid", {31'd0, rx_valid}, {31'd0, q.size() != 0});
            check("model_count", {29'd0, rx_count}, q.size());
            if (q.size() != 0) check("model_data", {24'd0, rx_data}, {24'd0, q[0]});
            check("fe_ov_exclusive", {31'd0, frame_err & overrun}, 32'd0);
        end
    end

    function automatic void model_push(input logic [7:0] b, input bit popping);
        if (popping && q.size() > 0) void'(q.pop_front());
        if (q.size() == DEPTH) exp_ov++;
        else q.push_back(b);
    endfunction

    // ready_c: frame cycle to assert rx_ready; abort_c: frame cycle to pulse reset.
    task automatic send_frame(input logic [7:0] b, input int ready_c, input int abort_c);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int c = 0; c < 10*BIT; c++) begin
            @(negedge clk);
            rxd      = fr[c/BIT];
            rx_ready = (c == ready_c);
            if (c == abort_c) reset = 1'b1;
            @(posedge clk);
            if (c == abort_c) begin
                q.delete();
                @(negedge clk);
                reset    = 1'b0;
                rxd      = 1'b1;
                rx_ready = 1'b0;
                return;
            end
            if (c == C_PUSH) model_push(b, c == ready_c);
        end
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        @(negedge clk);
        check(name, {24'd0, rx_data}, {24'd0, exp});
        rx_ready = 1'b1;
        @(posedge clk);
        if (q.size() > 0) void'(q.pop_front());
        #1 rx_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int fs, rel, ov_base, fe_base;
    bit busy_glitch;

    initial begin
        reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_count", {29'd0, rx_count}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        chk_en = 1;
        idle(50);

        // Single frame 0xA5
        fs = cyc;
        send_frame(8'hA5, -1, -1);
        check("a5_rise_window", {31'd0, (vrise_cyc - fs >= 9*BIT) && (vrise_cyc - fs <= 10*BIT)}, 32'd1);
        check("a5_data", {24'd0, rx_data}, 32'h0000_00A5);
        check("a5_count", {29'd0, rx_count}, 32'd1);
        pop_expect("a5_pop", 8'hA5);
        @(negedge clk);
        check("a5_empty_valid", {31'd0, rx_valid}, 32'd0);
        check("a5_empty_count", {29'd0, rx_count}, 32'd0);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rx_ready = 1'b0;

        // 200 ns glitch
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        busy_glitch = busy;
        repeat (10) @(negedge clk);
        idle(2*BIT);
        check("glitch_busy_seen", {31'd0, busy_glitch}, 32'd1);
        check("glitch_busy_done", {31'd0, busy}, 32'd0);
        check("glitch_no_fe", fe_cnt, 32'd0);
        check("glitch_no_push", {31'd0, rx_valid}, 32'd0);

        // Line held low from reset
        rxd = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rel = cyc;
        repeat (30*BIT) @(negedge clk);
        check("low_fe_once", fe_cnt, 32'd1);
        check("low_fe_window", {31'd0, (fe_cyc - rel >= 9*BIT) && (fe_cyc - rel <= 10*BIT)}, 32'd1);
        check("low_no_valid", {31'd0, rx_valid}, 32'd0);
        check("low_busy", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("low_release_busy", {31'd0, busy}, 32'd0);
        idle(2*BIT);

        // Five bytes into a 4-deep FIFO
        ov_base = ov_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), -1, -1);
        fs = cyc;
        send_frame(8'h05, -1, -1);
        check("ovr_pulses", ov_cnt - ov_base, 32'd1);
        check("ovr_model", ov_cnt, exp_ov);
        check("ovr_at_fifth_stop", {31'd0, (ov_cyc - fs >= 9*BIT) && (ov_cyc - fs <= 10*BIT)}, 32'd1);
        check("ovr_count", {29'd0, rx_count}, 32'd4);
        pop_expect("ovr_drain1", 8'h01);
        pop_expect("ovr_drain2", 8'h02);
        pop_expect("ovr_drain3", 8'h03);
        pop_expect("ovr_drain4", 8'h04);

        // Full FIFO, pop on the push edge
        ov_base = ov_cnt;
        for (int i = 10; i <= 13; i++) send_frame(8'(i), -1, -1);
        send_frame(8'h06, C_PUSH, -1);
        check("full_pp_no_ovr", ov_cnt, ov_base);
        check("full_pp_count", {29'd0, rx_count}, 32'd4);
        pop_expect("full_drain1", 8'h0B);
        pop_expect("full_drain2", 8'h0C);
        pop_expect("full_drain3", 8'h0D);
        pop_expect("full_drain4", 8'h06);

        // Reset in the middle of 0x3C, then a clean 0x5A
        fe_base = fe_cnt;
        ov_base = ov_cnt;
        send_frame(8'h3C, -1, 5*BIT + BIT/2);
        idle(2*BIT);
        check("abort_no_fe", fe_cnt, fe_base);
        check("abort_no_ovr", ov_cnt, ov_base);
        check("abort_no_valid", {31'd0, rx_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h5A, -1, -1);
        check("after_abort_count", {29'd0, rx_count}, 32'd1);
        pop_expect("after_abort_data", 8'h5A);
        idle(10);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
